// File: rtl/avalon_sw_led_io.sv
// Avalon-MM slave: synchronized/debounced switch inputs and a CPU-driven LED register with set/clear aliases.
// Define AVALON_SW_LED_IO_IRQ_EN to build edge capture, IRQ_MASK and the irq output.
module avalon_sw_led_io #(
  parameter int SW_W            = 10,
  parameter int LED_W           = 10,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [2:0]        avs_address,
  input  logic              avs_read,
  input  logic              avs_write,
  input  logic [31:0]       avs_writedata,
  output logic [31:0]       avs_readdata,
  output logic              irq,
  input  logic [SW_W-1:0]   sw_in,
  output logic [LED_W-1:0]  led_out
);

  // Bus handshake: there is no waitrequest, so a transfer completes on the edge where
  // avs_read/avs_write is sampled high. Read data is registered on that edge (latency 1)
  // and held until the next read; read+write together returns the pre-write value.

  localparam logic [2:0] ADDR_DATA_IN  = 3'd0;
  localparam logic [2:0] ADDR_LED      = 3'd1;
  localparam logic [2:0] ADDR_LED_SET  = 3'd2;
  localparam logic [2:0] ADDR_LED_CLR  = 3'd3;
  localparam logic [2:0] ADDR_EDGE_CAP = 3'd4;
  localparam logic [2:0] ADDR_IRQ_MASK = 3'd5;

  localparam int              CNT_W   = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_TOP = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0][SW_W-1:0] sync_q;
  logic [SW_W-1:0]  sw_s;
  logic [CNT_W-1:0] cnt_q;
  logic             tick;
  logic [SW_W-1:0]  prev_sample;
  logic [SW_W-1:0]  debounced;
  logic [SW_W-1:0]  stable;
  logic [LED_W-1:0] led_q;
  logic [LED_W-1:0] wdata_led;
  logic [31:0]      rd_next;

  // Every writedata bit is folded here so unused upper bits stay quiet in lint.
  logic unused_wdata;
  assign unused_wdata = &{1'b0, avs_writedata};

  // Synchronizer chain.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], sw_in};
    end
  end

  assign sw_s = sync_q[SYNC_STAGES-1];

  // Free-running sample period counter.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else if (tick) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign tick = (cnt_q == CNT_TOP);

  // A bit is accepted only when two consecutive tick samples agree.
  assign stable = ~(sw_s ^ prev_sample);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prev_sample <= '0;
      debounced   <= '0;
    end else if (tick) begin
      prev_sample <= sw_s;
      debounced   <= (stable & sw_s) | (~stable & debounced);
    end
  end

  // LED register and its atomic set/clear aliases.
  assign wdata_led = avs_writedata[LED_W-1:0];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      led_q <= '0;
    end else if (avs_write) begin
      case (avs_address)
        ADDR_LED:     led_q <= wdata_led;
        ADDR_LED_SET: led_q <= led_q | wdata_led;
        ADDR_LED_CLR: led_q <= led_q & ~wdata_led;
        default:      led_q <= led_q;
      endcase
    end
  end

  assign led_out = led_q;

`ifdef AVALON_SW_LED_IO_IRQ_EN
  logic [SW_W-1:0] deb_d;
  logic [SW_W-1:0] edge_cap;
  logic [SW_W-1:0] irq_mask;
  logic [SW_W-1:0] w1c;
  logic            irq_q;

  assign w1c = (avs_write && (avs_address == ADDR_EDGE_CAP)) ? avs_writedata[SW_W-1:0] : '0;

  // Set is OR-ed in after the W1C mask so a same-cycle edge survives the clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      deb_d    <= '0;
      edge_cap <= '0;
      irq_mask <= '0;
      irq_q    <= 1'b0;
    end else begin
      deb_d    <= debounced;
      edge_cap <= (edge_cap & ~w1c) | (debounced ^ deb_d);
      if (avs_write && (avs_address == ADDR_IRQ_MASK)) begin
        irq_mask <= avs_writedata[SW_W-1:0];
      end
      irq_q    <= |(edge_cap & irq_mask);
    end
  end

  assign irq = irq_q;
`else
  assign irq = 1'b0;
`endif

  // Read mux; unimplemented bits and addresses return zero.
  always_comb begin
    rd_next = '0;
    case (avs_address)
      ADDR_DATA_IN:  rd_next[SW_W-1:0]  = debounced;
      ADDR_LED:      rd_next[LED_W-1:0] = led_q;
`ifdef AVALON_SW_LED_IO_IRQ_EN
      ADDR_EDGE_CAP: rd_next[SW_W-1:0]  = edge_cap;
      ADDR_IRQ_MASK: rd_next[SW_W-1:0]  = irq_mask;
`endif
      default:       rd_next = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      avs_readdata <= '0;
    end else if (avs_read) begin
      avs_readdata <= rd_next;
    end
  end

endmodule

// File: tb/tb_avalon_sw_led_io.sv
// Directed bench for avalon_sw_led_io: register table plus hand-timed debounce, edge, irq and reset sequences.
`timescale 1ns/1ps
module tb_avalon_sw_led_io;

  localparam int SW_W        = 10;
  localparam int LED_W       = 10;
  localparam int SYNC_STAGES = 2;
  localparam int DEB         = 4;
`ifdef AVALON_SW_LED_IO_IRQ_EN
  localparam bit IRQ_EN = 1'b1;
`else
  localparam bit IRQ_EN = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic [2:0]        avs_address = '0;
  logic              avs_read = 1'b0;
  logic              avs_write = 1'b0;
  logic [31:0]       avs_writedata = '0;
  logic [31:0]       avs_readdata;
  logic              irq;
  logic [SW_W-1:0]   sw_in = '0;
  logic [LED_W-1:0]  led_out;

  avalon_sw_led_io #(
    .SW_W(SW_W), .LED_W(LED_W), .SYNC_STAGES(SYNC_STAGES), .DEBOUNCE_CYCLES(DEB)
  ) dut (
    .clk(clk), .reset_n(reset_n), .avs_address(avs_address), .avs_read(avs_read),
    .avs_write(avs_write), .avs_writedata(avs_writedata), .avs_readdata(avs_readdata),
    .irq(irq), .sw_in(sw_in), .led_out(led_out)
  );

  // Clock / reset block; cyc counts posedges since reset release (mirrors the sample period phase).
  always #5 clk = ~clk;

  int unsigned cyc;
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) cyc <= 0;
    else          cyc <= cyc + 1;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, required run to finish");
    $fatal(1);
  end

  // Scoreboard.
  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Driver tasks: entered and left just after a falling edge.
  task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
    avs_address = a; avs_writedata = d; avs_write = 1'b1;
    @(negedge clk);
    avs_write = 1'b0;
  endtask

  task automatic bus_read(input logic [2:0] a, output logic [31:0] d);
    avs_address = a; avs_read = 1'b1;
    @(negedge clk);
    avs_read = 1'b0;
    d = avs_readdata;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_phase(input int unsigned p);
    int unsigned guard;
    guard = 0;
    while (((cyc % 4) != p) && (guard < 8)) begin
      @(negedge clk);
      guard++;
    end
  endtask

  typedef struct {
    bit          wr;
    logic [2:0]  addr;
    logic [31:0] data;
    logic [31:0] exp;
  } vec_t;

  vec_t        vecs[$];
  logic [31:0] rd;
  logic [31:0] e;
  bit          found;
  int          lat;

  initial begin
    // Register vectors: reads check avs_readdata, writes check led_out.
    for (int a = 0; a < 8; a++) vecs.push_back('{1'b0, 3'(a), 32'h0, 32'h0});
    vecs.push_back('{1'b1, 3'd1, 32'h2A5,      32'h2A5});
    vecs.push_back('{1'b0, 3'd1, 32'h0,        32'h2A5});
    vecs.push_back('{1'b1, 3'd1, 32'h00F,      32'h00F});
    vecs.push_back('{1'b1, 3'd2, 32'h300,      32'h30F});
    vecs.push_back('{1'b1, 3'd3, 32'h005,      32'h30A});
    vecs.push_back('{1'b0, 3'd2, 32'h0,        32'h0});
    vecs.push_back('{1'b0, 3'd3, 32'h0,        32'h0});
    vecs.push_back('{1'b0, 3'd1, 32'h0,        32'h30A});
    vecs.push_back('{1'b1, 3'd6, 32'hFFF,      32'h30A});
    vecs.push_back('{1'b0, 3'd6, 32'h0,        32'h0});
    vecs.push_back('{1'b1, 3'd1, 32'hFFFFFFFF, 32'h3FF});
    vecs.push_back('{1'b0, 3'd1, 32'h0,        32'h3FF});

    // Reset state.
    #12;
    check("reset_led_out", 32'(led_out), 32'h0);
    check("reset_irq", 32'(irq), 32'h0);
    check("reset_readdata", avs_readdata, 32'h0);
    @(negedge clk); @(negedge clk);
    reset_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      if (vecs[i].wr) begin
        bus_write(vecs[i].addr, vecs[i].data);
        check($sformatf("vec%0d_led_out", i), 32'(led_out), vecs[i].exp);
      end else begin
        exp_q.push_back(vecs[i].exp);
        bus_read(vecs[i].addr, rd);
        e = exp_q.pop_front();
        check($sformatf("vec%0d_read_a%0d", i, vecs[i].addr), rd, e);
      end
    end

    // Read data holds between reads; read+write returns pre-write data.
    idle(3);
    check("readdata_hold", avs_readdata, 32'h3FF);
    avs_address = 3'd1; avs_writedata = 32'h155; avs_read = 1'b1; avs_write = 1'b1;
    @(negedge clk);
    avs_read = 1'b0; avs_write = 1'b0;
    check("rw_same_cycle_read", avs_readdata, 32'h3FF);
    check("rw_same_cycle_led", 32'(led_out), 32'h155);
    check("reset_irq_idle", 32'(irq), 32'h0);

    // Debounce: toggle every 2 cycles, phased so every tick samples 0.
    wait_phase(1);
    for (int i = 0; i < 20; i++) begin
      sw_in[0] = ((cyc % 4) == 3) || ((cyc % 4) == 0);
      avs_address = 3'd0; avs_read = 1'b1;
      @(negedge clk);
      check("deb_toggle_data_in", avs_readdata, 32'h0);
    end
    sw_in[0] = 1'b1;
    found = 1'b0;
    lat = 0;
    for (int i = 0; i < 10; i++) begin
      if (!found) begin
        avs_address = 3'd0; avs_read = 1'b1;
        @(negedge clk);
        lat++;
        if (avs_readdata == 32'h1) found = 1'b1;
      end
    end
    avs_read = 1'b0;
    check("deb_hold_accepted", 32'(found), 32'h1);
    check("deb_hold_latency", 32'(lat), 32'd8);
    idle(2);
    bus_read(3'd4, rd);
    check("deb_edge_cap_once", rd, IRQ_EN ? 32'h1 : 32'h0);
    bus_write(3'd4, 32'h1);
    idle(12);
    bus_read(3'd4, rd);
    check("deb_no_second_edge", rd, 32'h0);

    // Interrupt: masked-off edge first, then enabled edge and W1C clear.
    sw_in[0] = 1'b0;
    idle(16);
    bus_read(3'd4, rd);
    check("mask0_edge_cap", rd, IRQ_EN ? 32'h1 : 32'h0);
    check("mask0_irq_low", 32'(irq), 32'h0);
    bus_read(3'd0, rd);
    check("fall_data_in", rd, 32'h0);
    bus_write(3'd4, 32'h1);
    bus_write(3'd5, 32'h1);
    bus_read(3'd5, rd);
    check("irq_mask_read", rd, IRQ_EN ? 32'h1 : 32'h0);
    sw_in[0] = 1'b1;
    idle(16);
    bus_read(3'd4, rd);
    check("irq_edge_cap", rd, IRQ_EN ? 32'h1 : 32'h0);
    check("irq_high", 32'(irq), IRQ_EN ? 32'h1 : 32'h0);
    bus_write(3'd4, 32'h1);
    check("irq_one_cycle_after_w1c", 32'(irq), IRQ_EN ? 32'h1 : 32'h0);
    @(negedge clk);
    check("irq_two_cycles_after_w1c", 32'(irq), 32'h0);

    // W1C of bit 3 lands on the same edge that sets edge_cap[3].
    wait_phase(1);
    sw_in[3] = 1'b1;
    idle(7);
    bus_write(3'd4, 32'h8);
    bus_read(3'd4, rd);
    check("set_beats_w1c", rd, IRQ_EN ? 32'h8 : 32'h0);
    bus_read(3'd0, rd);
    check("data_in_bits_0_3", rd, 32'h9);
    check("unmasked_bit_no_irq", 32'(irq), 32'h0);

    // Reset mid-operation.
    bus_write(3'd1, 32'h3FF);
    sw_in[0] = 1'b0;
    idle(16);
    check("pre_reset_irq", 32'(irq), IRQ_EN ? 32'h1 : 32'h0);
    bus_read(3'd1, rd);
    check("pre_reset_led", rd, 32'h3FF);
    wait_phase(2);
    #2;
    reset_n = 1'b0;
    #1;
    check("async_reset_led_out", 32'(led_out), 32'h0);
    check("async_reset_irq", 32'(irq), 32'h0);
    check("async_reset_readdata", avs_readdata, 32'h0);
    @(negedge clk); @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      bus_read(3'd0, rd);
      check($sformatf("restart_data_in_%0d", i), rd, (i >= 8) ? 32'h8 : 32'h0);
    end
    bus_read(3'd1, rd);
    check("post_reset_led", rd, 32'h0);
    bus_read(3'd5, rd);
    check("post_reset_mask", rd, 32'h0);
    bus_read(3'd4, rd);
    check("post_reset_edge_cap", rd, IRQ_EN ? 32'h8 : 32'h0);
    check("post_reset_irq", 32'(irq), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
